// File: rtl/fsk_ctrl_pkg.sv
// Shared definitions for the FSK frame transmit controller.
//   - State encoding for the frame FSM (IDLE, START, DATA, PARITY, STOP).
//   - Frame constants: DATA_BITS data symbols per frame, IDLE_LEVEL line level.
//   - even_parity(): parity symbol value for the optional parity slot.
package fsk_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } fsk_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity: the parity symbol makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fsk_symbol_timer.sv
// Symbol timer: counts sample clocks 0..SYMBOL_CYCLES-1 within one symbol and
// wraps to 0 on every symbol boundary.
// Ports:
//   clk_sample  in  sample clock
//   rst         in  asynchronous active-high reset
//   clear       in  hold counter at 0 (has priority over enable)
//   enable      in  advance counter
//   sym_first   out counter == 0 (first cycle of symbol)
//   sym_last    out counter == SYMBOL_CYCLES-1 (last cycle of symbol)
//   sym_penult  out counter == SYMBOL_CYCLES-2 (next cycle is the last one)
module fsk_symbol_timer #(
  parameter int SYMBOL_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic clk_sample,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic sym_first,
  output logic sym_last,
  output logic sym_penult
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(SYMBOL_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign sym_first  = (cnt == '0);
  assign sym_last   = (cnt == CNT_LAST);
  assign sym_penult = (cnt == CNT_PENULT);

endmodule

// File: rtl/fsk_frame_tx_ctrl.sv
// FSK frame transmit controller: takes bytes on a valid/ready handshake and
// frames them UART-style (start, 8 data LSB-first, optional parity, stop),
// holding each symbol on fsk_bit for SYMBOL_CYCLES sample clocks.
// Optional feature: define FSK_TX_PARITY_EN to insert an even-parity symbol
// between the data bits and the stop bit(s).
// Ports:
//   clk_sample  in   sample clock
//   rst         in   asynchronous active-high reset
//   byte_data   in   byte to transmit (sampled only on accept)
//   byte_valid  in   byte_data valid
//   byte_ready  out  byte can be accepted this cycle
//   fsk_bit     out  serial symbol to modulator (1=mark, 0=space)
//   sym_strobe  out  pulse on first cycle of every symbol
//   busy        out  frame in progress
//   frame_done  out  pulse on last cycle of final stop symbol
// All outputs are registered: each is loaded from the value it must show in
// the cycle the FSM state register enters.
module fsk_frame_tx_ctrl
  import fsk_ctrl_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 64,
  parameter int STOP_BITS     = 1,
  parameter int CNT_W         = 16
) (
  input  logic       clk_sample,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       fsk_bit,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done
);

  localparam logic STOP_LAST = (STOP_BITS == 2);

  fsk_state_t state, state_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic       stop_cnt, stop_cnt_n;
  logic [7:0] shift_q;
  logic       parity_q;
  logic       sym_first, sym_last, sym_penult;
  logic       accept, ending_n;
  logic       fsk_bit_n, sym_strobe_n, busy_n, frame_done_n, byte_ready_n;

  assign accept = byte_valid & byte_ready;

  fsk_symbol_timer #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk_sample(clk_sample),
    .rst       (rst),
    .clear     (state == IDLE),
    .enable    (1'b1),
    .sym_first (sym_first),
    .sym_last  (sym_last),
    .sym_penult(sym_penult)
  );

  // Next-state logic
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    case (state)
      IDLE:  if (accept) state_n = START;
      START: if (sym_last) begin
        state_n   = DATA;
        bit_idx_n = '0;
      end
      DATA: if (sym_last) begin
        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef FSK_TX_PARITY_EN
          state_n    = PARITY;
`else
          state_n    = STOP;
          stop_cnt_n = 1'b0;
`endif
        end else begin
          bit_idx_n = bit_idx + 3'd1;
        end
      end
      PARITY: if (sym_last) begin
        state_n    = STOP;
        stop_cnt_n = 1'b0;
      end
      STOP: if (sym_last) begin
        if (stop_cnt == STOP_LAST) state_n = accept ? START : IDLE;
        else                       stop_cnt_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the cycle the FSM moves into
  always_comb begin
    fsk_bit_n = IDLE_LEVEL;
    case (state_n)
      START: fsk_bit_n = 1'b0;
      // Entering DATA shows bit 0; later boundaries show the next bit, which
      // sits at shift_q[1] because the register shifts at each symbol's start.
      DATA:  fsk_bit_n = (state == START) ? shift_q[0] :
                         (sym_last ? shift_q[1] : fsk_bit);
`ifdef FSK_TX_PARITY_EN
      PARITY: fsk_bit_n = parity_q;
`endif
      default: fsk_bit_n = IDLE_LEVEL;
    endcase
    sym_strobe_n = (state_n != IDLE) && ((state == IDLE) || sym_last);
    busy_n       = (state_n != IDLE);
    // Next cycle is the last cycle of the final stop symbol.
    ending_n     = (state == STOP) && (stop_cnt == STOP_LAST) && sym_penult;
    frame_done_n = ending_n;
    byte_ready_n = (state_n == IDLE) || ending_n;
  end

  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      fsk_bit    <= IDLE_LEVEL;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      sym_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      stop_cnt   <= stop_cnt_n;
      fsk_bit    <= fsk_bit_n;
      byte_ready <= byte_ready_n;
      busy       <= busy_n;
      sym_strobe <= sym_strobe_n;
      frame_done <= frame_done_n;
    end
  end

  // Data path: no reset needed, contents only matter after an accept.
  always_ff @(posedge clk_sample) begin
    if (accept) begin
      shift_q  <= byte_data;
      parity_q <= even_parity(byte_data);
    end else if ((state == DATA) && sym_first && (bit_idx != 3'd0)) begin
      shift_q  <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_fsk_frame_tx_ctrl.sv
module tb_fsk_frame_tx_ctrl;

  localparam int SC = 4;
`ifdef FSK_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d1, d2;
  logic       v1, v2;
  logic       r1, f1, s1, b1, fd1;
  logic       r2, f2, s2, b2, fd2;

  fsk_frame_tx_ctrl #(.SYMBOL_CYCLES(SC), .STOP_BITS(1), .CNT_W(16)) dut (
    .clk_sample(clk), .rst(rst), .byte_data(d1), .byte_valid(v1),
    .byte_ready(r1), .fsk_bit(f1), .sym_strobe(s1), .busy(b1), .frame_done(fd1)
  );

  fsk_frame_tx_ctrl #(.SYMBOL_CYCLES(SC), .STOP_BITS(2), .CNT_W(16)) dut2 (
    .clk_sample(clk), .rst(rst), .byte_data(d2), .byte_valid(v2),
    .byte_ready(r2), .fsk_bit(f2), .sym_strobe(s2), .busy(b2), .frame_done(fd2)
  );

  typedef struct packed {
    logic fsk;
    logic strobe;
    logic done;
    logic ready;
    logic busy;
  } obs_t;

  obs_t q1[$];
  obs_t q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input int which);
    obs_t o;
    if (which == 1) o = '{fsk: f1, strobe: s1, done: fd1, ready: r1, busy: b1};
    else            o = '{fsk: f2, strobe: s2, done: fd2, ready: r2, busy: b2};
    return o;
  endfunction

  // Reference frame model: per-cycle expected outputs for one byte.
  task automatic push_frame(input int which, input logic [7:0] b, input int stop_bits);
    logic syms[$];
    obs_t e;
    logic last;
    syms.push_back(1'b0);
    for (int i = 0; i < 8; i++) syms.push_back(b[i]);
    if (PAR_EN == 1) syms.push_back(^b);
    for (int s = 0; s < stop_bits; s++) syms.push_back(1'b1);
    for (int k = 0; k < syms.size(); k++) begin
      for (int c = 0; c < SC; c++) begin
        last     = (k == syms.size() - 1) && (c == SC - 1);
        e.fsk    = syms[k];
        e.strobe = (c == 0);
        e.busy   = 1'b1;
        e.done   = last;
        e.ready  = last;
        if (which == 1) q1.push_back(e);
        else            q2.push_back(e);
      end
    end
  endtask

  task automatic check_cycles(input int which, input int n, input string tag);
    obs_t o, e;
    for (int i = 0; i < n; i++) begin
      o = sample(which);
      if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s_underflow observed=empty expected=entry", tag);
      end else begin
        if (which == 1) e = q1.pop_front();
        else            e = q2.pop_front();
        chk({tag, "_fsk"},    o.fsk,    e.fsk);
        chk({tag, "_strobe"}, o.strobe, e.strobe);
        chk({tag, "_done"},   o.done,   e.done);
        chk({tag, "_ready"},  o.ready,  e.ready);
        chk({tag, "_busy"},   o.busy,   e.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input int which, input string tag);
    obs_t o;
    o = sample(which);
    chk({tag, "_fsk"},    o.fsk,    1'b1);
    chk({tag, "_busy"},   o.busy,   1'b0);
    chk({tag, "_ready"},  o.ready,  1'b1);
    chk({tag, "_strobe"}, o.strobe, 1'b0);
    chk({tag, "_done"},   o.done,   1'b0);
    if (which == 1) chk({tag, "_qempty"}, q1.size() == 0, 1'b1);
    else            chk({tag, "_qempty"}, q2.size() == 0, 1'b1);
  endtask

  // Wait (bounded) for byte_ready, then present one byte for one cycle.
  task automatic send(input int which, input logic [7:0] b);
    obs_t o;
    int w = 0;
    o = sample(which);
    while (o.ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
      o = sample(which);
    end
    chk("send_ready", o.ready, 1'b1);
    if (which == 1) begin v1 = 1'b1; d1 = b; end
    else            begin v2 = 1'b1; d2 = b; end
    @(negedge clk);
    if (which == 1) v1 = 1'b0;
    else            v2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; d1 = 8'h00; d2 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_fsk",    f1,  1'b1);
    chk("rst_busy",   b1,  1'b0);
    chk("rst_ready",  r1,  1'b0);
    chk("rst_strobe", s1,  1'b0);
    chk("rst_done",   fd1, 1'b0);
    chk("rst_ready2", r2,  1'b0);
    rst = 1'b0;
    #1;
    chk("rel_ready_before_clk", r1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check_idle(1, "idle_after_rel");
      @(negedge clk);
    end

    // Single frame 0xA5
    push_frame(1, 8'hA5, 1);
    send(1, 8'hA5);
    check_cycles(1, 10 * SC + PAR_EN * SC, "a5");
    check_idle(1, "a5_idle");

    // Back-to-back 0x00 then 0xFF with byte_valid held high
    push_frame(1, 8'h00, 1);
    push_frame(1, 8'hFF, 1);
    v1 = 1'b1; d1 = 8'h00;
    @(negedge clk);
    d1 = 8'hFF;
    check_cycles(1, (10 + PAR_EN) * SC, "b2b_first");
    v1 = 1'b0;
    check_cycles(1, (10 + PAR_EN) * SC, "b2b_second");
    check_idle(1, "b2b_idle");

    // byte_valid pulse mid-frame must be ignored
    push_frame(1, 8'h96, 1);
    send(1, 8'h96);
    check_cycles(1, 10, "pulse_pre");
    v1 = 1'b1; d1 = 8'h5A;
    check_cycles(1, 1, "pulse_at");
    v1 = 1'b0; d1 = 8'h00;
    check_cycles(1, (10 + PAR_EN) * SC - 11, "pulse_post");
    check_idle(1, "pulse_idle");

    // Reset during data bit 3 of 0x3C, then 0x81
    push_frame(1, 8'h3C, 1);
    send(1, 8'h3C);
    check_cycles(1, 17, "abort_pre");
    rst = 1'b1;
    #1;
    chk("abort_fsk",   f1,  1'b1);
    chk("abort_busy",  b1,  1'b0);
    chk("abort_ready", r1,  1'b0);
    chk("abort_done",  fd1, 1'b0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle(1, "abort_idle");
    push_frame(1, 8'h81, 1);
    send(1, 8'h81);
    check_cycles(1, (10 + PAR_EN) * SC, "after_abort_81");
    check_idle(1, "after_abort_idle");

    // Parity-relevant byte 0x07 (parity symbol present only when enabled)
    push_frame(1, 8'h07, 1);
    send(1, 8'h07);
    check_cycles(1, (10 + PAR_EN) * SC, "par07");
    check_idle(1, "par07_idle");

    // Two stop bits on the second instance
    push_frame(2, 8'h00, 2);
    send(2, 8'h00);
    check_cycles(2, (11 + PAR_EN) * SC, "stop2");
    check_idle(2, "stop2_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
